// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller states and the default register index width.
package pipeline_pkg;

  // Default width of a register index (32 architectural registers)
  localparam int REG_ADDR_W_DEF = 5;

  // Operand source select for the EX stage ALU inputs
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Controller state: normal issue, or holding while a multicycle op runs
  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding selects. The younger producer in MEM
// wins over WB, and register x0 is never forwarded. The enable input lets
// the parent force both selects back to the register file.
module hazard_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  fwd_en,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b
);

  logic memValid;
  logic wbValid;

  // A stage can forward only if it writes a real (non-x0) register
  always_comb begin
    memValid = mem_reg_write && (mem_rd != '0);
    wbValid  = wb_reg_write && (wb_rd != '0);
  end

  // Pick the source for each operand, MEM first then WB then register file
  always_comb begin
    ex_fwd_a = FWD_RF;
    ex_fwd_b = FWD_RF;
    if (fwd_en) begin
      if (memValid && (mem_rd == ex_rs1)) begin
        ex_fwd_a = FWD_MEM;
      end else if (wbValid && (wb_rd == ex_rs1)) begin
        ex_fwd_a = FWD_WB;
      end
      if (memValid && (mem_rd == ex_rs2)) begin
        ex_fwd_b = FWD_MEM;
      end else if (wbValid && (wb_rd == ex_rs2)) begin
        ex_fwd_b = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core. Generates stall and
// flush controls for every pipeline register, handles load-use hazards,
// taken branches/jumps and the multicycle start/done handshake, and provides
// the EX forwarding selects.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall-cycle and
// flush-event counters as extra output ports.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_pc_src,
  input  logic                  ex_mc_op,
  input  logic                  mc_done,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  output logic                  if_stall,
  output logic                  de_stall,
  output logic                  ex_stall,
  output logic                  de_flush,
  output logic                  ex_flush,
  output logic                  mem_flush,
  output logic                  mc_start,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_events
`endif
);

  hz_state_t state_q;
  hz_state_t state_d;
  logic      loadUse;

  // A load in EX feeding either DE source register needs one bubble; x0 is exempt
  always_comb begin
    loadUse = ex_is_load && (ex_rd != '0) &&
              ((ex_rd == de_rs1) || (ex_rd == de_rs2));
  end

  // Next state and all control outputs, decoded from state and current inputs
  always_comb begin
    state_d   = state_q;
    if_stall  = 1'b0;
    de_stall  = 1'b0;
    ex_stall  = 1'b0;
    de_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    mc_start  = 1'b0;
    if (rst) begin
      de_flush  = 1'b1;
      ex_flush  = 1'b1;
      mem_flush = 1'b1;
      state_d   = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_pc_src) begin
            de_flush = 1'b1;
            ex_flush = 1'b1;
          end else if (ex_mc_op) begin
            mc_start  = 1'b1;
            if_stall  = 1'b1;
            de_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_flush = 1'b1;
            state_d   = MC_WAIT;
          end else if (loadUse) begin
            if_stall = 1'b1;
            de_stall = 1'b1;
            ex_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_d = RUN;
          end else begin
            if_stall  = 1'b1;
            de_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_flush = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State register; reset abandons any multicycle op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Forwarding selects, held at register-file during reset
  hazard_fwd_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd (
    .fwd_en       (!rst),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_reg_write(mem_reg_write),
    .wb_reg_write (wb_reg_write),
    .ex_fwd_a     (ex_fwd_a),
    .ex_fwd_b     (ex_fwd_b)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt_q;
  logic [31:0] flushCnt_q;

  // Saturating event counters; de_flush is asserted in reset but reset clears first
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (if_stall && (stallCnt_q != 32'hFFFF_FFFF)) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
      if (de_flush && (flushCnt_q != 32'hFFFF_FFFF)) begin
        flushCnt_q <= flushCnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stallCnt_q;
  assign perf_flush_events = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Each stimulus cycle pushes its
// expected control vector into a scoreboard queue; an independent monitor
// pops and compares on the falling edge.
// Vector layout: {if_stall, de_stall, ex_stall, de_flush, ex_flush,
//                 mem_flush, mc_start, ex_fwd_a[1:0], ex_fwd_b[1:0]}
module tb_pipeline_hazard_ctrl;

  localparam int W = 5;

  localparam logic [10:0] E_IDLE = 11'b000_000_0_00_00;
  localparam logic [10:0] E_RST  = 11'b000_111_0_00_00;
  localparam logic [10:0] E_LU   = 11'b110_010_0_00_00;
  localparam logic [10:0] E_BR   = 11'b000_110_0_00_00;
  localparam logic [10:0] E_MCS  = 11'b111_001_1_00_00;
  localparam logic [10:0] E_MCW  = 11'b111_001_0_00_00;

  logic         clk;
  logic         rst;
  logic [W-1:0] deRs1, deRs2, exRs1, exRs2, exRd, memRd, wbRd;
  logic         exIsLoad, exPcSrc, exMcOp, mcDone, memRegWrite, wbRegWrite;
  logic         ifStall, deStall, exStall, deFlush, exFlush, memFlush, mcStart;
  logic [1:0]   exFwdA, exFwdB;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]  perfStall, perfFlush;
`endif

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sbItem_t;

  sbItem_t sbQ[$];
  int      testsRun = 0;
  int      testsFailed = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .de_rs1       (deRs1),
    .de_rs2       (deRs2),
    .ex_rs1       (exRs1),
    .ex_rs2       (exRs2),
    .ex_rd        (exRd),
    .ex_is_load   (exIsLoad),
    .ex_pc_src    (exPcSrc),
    .ex_mc_op     (exMcOp),
    .mc_done      (mcDone),
    .mem_rd       (memRd),
    .wb_rd        (wbRd),
    .mem_reg_write(memRegWrite),
    .wb_reg_write (wbRegWrite),
    .if_stall     (ifStall),
    .de_stall     (deStall),
    .ex_stall     (exStall),
    .de_flush     (deFlush),
    .ex_flush     (exFlush),
    .mem_flush    (memFlush),
    .mc_start     (mcStart),
    .ex_fwd_a     (exFwdA),
    .ex_fwd_b     (exFwdB)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles(perfStall),
    .perf_flush_events(perfFlush)
`endif
  );

  // Free-running core clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge and return inputs to idle
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    deRs1 = '0; deRs2 = '0; exRs1 = '0; exRs2 = '0; exRd = '0;
    memRd = '0; wbRd = '0;
    exIsLoad = 1'b0; exPcSrc = 1'b0; exMcOp = 1'b0; mcDone = 1'b0;
    memRegWrite = 1'b0; wbRegWrite = 1'b0;
  endtask

  // Record the expected control vector for the inputs just driven
  task automatic applyStimulus(input string name, input logic [10:0] exp);
    sbItem_t item;
    item.name = name;
    item.exp  = exp;
    sbQ.push_back(item);
  endtask

  // Compare one scoreboard entry against the live DUT outputs
  task automatic checkOutput(input sbItem_t item);
    logic [10:0] act;
    act = {ifStall, deStall, exStall, deFlush, exFlush, memFlush, mcStart,
           exFwdA, exFwdB};
    testsRun++;
    if (act !== item.exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b expected %b", item.name, act, item.exp);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  // Compare the performance counters against hand-computed totals
  task automatic checkPerf(input string name, input logic [31:0] expStall,
                           input logic [31:0] expFlush);
    testsRun++;
    if ((perfStall !== expStall) || (perfFlush !== expFlush)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               name, perfStall, perfFlush, expStall, expFlush);
    end
  endtask
`endif

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      checkOutput(sbQ.pop_front());
    end
  end

  // Directed stimulus sequence
  initial begin
    rst = 1'b1;
    deRs1 = '0; deRs2 = '0; exRs1 = '0; exRs2 = '0; exRd = '0;
    memRd = '0; wbRd = '0;
    exIsLoad = 1'b0; exPcSrc = 1'b0; exMcOp = 1'b0; mcDone = 1'b0;
    memRegWrite = 1'b0; wbRegWrite = 1'b0;

    step(); rst = 1'b1; memRd = 5'd7; memRegWrite = 1'b1; exRs1 = 5'd7;
    applyStimulus("reset_outputs", E_RST);
    step(); applyStimulus("idle_after_reset", E_IDLE);

    step(); exIsLoad = 1'b1; exRd = 5'd5; deRs2 = 5'd5;
    applyStimulus("loaduse_rs2", E_LU);
    step(); applyStimulus("loaduse_one_cycle", E_IDLE);
    step(); exIsLoad = 1'b1; exRd = 5'd0;
    applyStimulus("loaduse_x0", E_IDLE);
    step(); exIsLoad = 1'b1; exRd = 5'd3; deRs1 = 5'd3; deRs2 = 5'd4;
    applyStimulus("loaduse_rs1", E_LU);
    step(); exRd = 5'd3; deRs1 = 5'd3;
    applyStimulus("no_load_no_stall", E_IDLE);

    step(); exPcSrc = 1'b1; exMcOp = 1'b1; exIsLoad = 1'b1; exRd = 5'd5; deRs1 = 5'd5;
    applyStimulus("branch_beats_mc", E_BR);
    step(); applyStimulus("branch_stays_run", E_IDLE);

    step(); exMcOp = 1'b1; mcDone = 1'b1;
    applyStimulus("mc_start_done_ignored", E_MCS);
    step(); exMcOp = 1'b1; exPcSrc = 1'b1;
    applyStimulus("mcwait_ignores_branch", E_MCW);
    step(); exMcOp = 1'b1; exIsLoad = 1'b1; exRd = 5'd2; deRs1 = 5'd2;
    applyStimulus("mcwait_ignores_loaduse", E_MCW);
    step(); exMcOp = 1'b1; exRs1 = 5'd7; wbRd = 5'd7; wbRegWrite = 1'b1;
    applyStimulus("mcwait_fwd_wb", 11'b111_001_0_01_00);
    step(); exMcOp = 1'b1; mcDone = 1'b1;
    applyStimulus("mc_done_release", E_IDLE);
    step(); applyStimulus("back_in_run", E_IDLE);

    step(); exMcOp = 1'b1;
    applyStimulus("mc_start_n1", E_MCS);
    step(); exMcOp = 1'b1; mcDone = 1'b1;
    applyStimulus("mc_done_n1", E_IDLE);
    step(); applyStimulus("idle_after_n1", E_IDLE);

    step(); memRd = 5'd7; wbRd = 5'd7; memRegWrite = 1'b1; wbRegWrite = 1'b1; exRs1 = 5'd7;
    applyStimulus("fwd_a_mem_prio", 11'b000_000_0_10_00);
    step(); memRd = 5'd7; wbRd = 5'd7; wbRegWrite = 1'b1; exRs1 = 5'd7;
    applyStimulus("fwd_a_wb", 11'b000_000_0_01_00);
    step(); memRegWrite = 1'b1; wbRegWrite = 1'b1;
    applyStimulus("fwd_x0", E_IDLE);
    step(); exRs1 = 5'd4; exRs2 = 5'd9; memRd = 5'd9; wbRd = 5'd9;
    memRegWrite = 1'b1; wbRegWrite = 1'b1;
    applyStimulus("fwd_b_mem", 11'b000_000_0_00_10);
    step(); exRs2 = 5'd9; memRd = 5'd9; wbRd = 5'd9; wbRegWrite = 1'b1;
    applyStimulus("fwd_b_wb", 11'b000_000_0_00_01);
    step(); exRs1 = 5'd6; exRs2 = 5'd6; memRd = 5'd6; memRegWrite = 1'b1;
    applyStimulus("fwd_ab_mem", 11'b000_000_0_10_10);

    step(); exMcOp = 1'b1;
    applyStimulus("mc_start_pre_reset", E_MCS);
    step(); rst = 1'b1; exMcOp = 1'b1;
    applyStimulus("reset_in_mcwait", E_RST);
    step(); applyStimulus("run_after_reset", E_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    checkPerf("perf_cleared", 32'd0, 32'd0);
`endif
    step(); mcDone = 1'b1;
    applyStimulus("stray_done_in_run", E_IDLE);
    step(); exIsLoad = 1'b1; exRd = 5'd8; deRs1 = 5'd8;
    applyStimulus("loaduse_after_reset", E_LU);
    step(); exPcSrc = 1'b1;
    applyStimulus("branch_after_reset", E_BR);
    step(); applyStimulus("final_idle", E_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    checkPerf("perf_counts", 32'd1, 32'd1);
`endif

    // Let the monitor drain, bounded so the run always terminates
    for (int i = 0; i < 5 && sbQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sbQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
